// File: rtl/hdmi_config_sequencer.sv
// Steps an ADV7513 register table out of a registered config ROM and hands each word to an I2C write master.
// Retries NACKed writes, stops at an all-zero word, and replays the table after every hot-plug rise.
module hdmi_config_sequencer #(
  parameter int bitLength     = 24,
  parameter int addressWidth  = 4,
  parameter int startupCycles = 10000000,
  parameter int maxRetries    = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    hotPlugDetect,
  output logic [addressWidth-1:0] romAddress,
  input  logic [bitLength-1:0]    romData,
  output logic                    i2cRequest,
  output logic [bitLength-1:0]    i2cWord,
  input  logic                    i2cDone,
  input  logic                    i2cAckError,
  output logic                    configDone,
  output logic                    configError
);

  // state      | meaning
  // STARTUP    | power-up hold-off, HPD ignored
  // FETCH      | ROM address applied, waiting one clock for data
  // CHECK      | terminator test, latch word and raise request
  // WAIT       | request held until the master reports done
  // BACKOFF    | one idle clock before re-requesting the same word
  // DONE       | table written, waiting for hot-plug
  // ERROR      | retries exhausted, waiting for hot-plug
  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_FETCH,
    ST_CHECK,
    ST_WAIT,
    ST_BACKOFF,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam int DELAY_W = (startupCycles > 1) ? $clog2(startupCycles) : 1;
  localparam int RETRY_W = (maxRetries > 0) ? $clog2(maxRetries + 1) : 1;
  localparam logic [DELAY_W-1:0]      DELAY_LAST = DELAY_W'(startupCycles - 1);
  localparam logic [RETRY_W-1:0]      RETRY_MAX  = RETRY_W'(maxRetries);
  localparam logic [addressWidth-1:0] ADDR_LAST  = '1;

  state_t                  state, state_n;
  logic [DELAY_W-1:0]      delay_cnt, delay_n;
  logic [RETRY_W-1:0]      retry_cnt, retry_n;
  logic                    restart, restart_n;
  logic [addressWidth-1:0] addr_q, addr_n;
  logic [bitLength-1:0]    word_q, word_n;
  logic                    hpd_meta, hpd_sync, hpd_prev, hpd_rise;
  logic                    restart_now;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_STARTUP;
      delay_cnt <= '0;
      retry_cnt <= '0;
      restart   <= 1'b0;
      addr_q    <= '0;
      word_q    <= '0;
      hpd_meta  <= 1'b0;
      hpd_sync  <= 1'b0;
      hpd_prev  <= 1'b0;
      hpd_rise  <= 1'b0;
    end else begin
      state     <= state_n;
      delay_cnt <= delay_n;
      retry_cnt <= retry_n;
      restart   <= restart_n;
      addr_q    <= addr_n;
      word_q    <= word_n;
      hpd_meta  <= hotPlugDetect;
      hpd_sync  <= hpd_meta;
      hpd_prev  <= hpd_sync;
      hpd_rise  <= hpd_sync & ~hpd_prev;
    end
  end

  // A rise arriving in the same cycle as a done counts as already pending.
  assign restart_now = restart | hpd_rise;

  always_comb begin
    state_n   = state;
    delay_n   = delay_cnt;
    retry_n   = retry_cnt;
    restart_n = restart;
    addr_n    = addr_q;
    word_n    = word_q;
    case (state)
      ST_STARTUP: begin
        if (delay_cnt == DELAY_LAST) begin
          delay_n = '0;
          addr_n  = '0;
          state_n = ST_FETCH;
        end else begin
          delay_n = delay_cnt + 1'b1;
        end
      end
      ST_FETCH: begin
        restart_n = restart_now;
        state_n   = ST_CHECK;
      end
      ST_CHECK: begin
        if (romData == '0) begin
          if (restart_now) begin
            restart_n = 1'b0;
            addr_n    = '0;
            state_n   = ST_FETCH;
          end else begin
            state_n = ST_DONE;
          end
        end else begin
          restart_n = restart_now;
          word_n    = romData;
          state_n   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        restart_n = restart_now;
        if (i2cDone) begin
          if (!i2cAckError) begin
            retry_n = '0;
            if (restart_now) begin
              restart_n = 1'b0;
              addr_n    = '0;
              state_n   = ST_FETCH;
            end else if (addr_q == ADDR_LAST) begin
              state_n = ST_DONE;
            end else begin
              addr_n  = addr_q + 1'b1;
              state_n = ST_FETCH;
            end
          end else if (retry_cnt < RETRY_MAX) begin
            retry_n = retry_cnt + 1'b1;
            state_n = ST_BACKOFF;
          end else if (restart_now) begin
            // the replay will rewrite this entry anyway, so skip ERROR
            retry_n   = '0;
            restart_n = 1'b0;
            addr_n    = '0;
            state_n   = ST_FETCH;
          end else begin
            state_n = ST_ERROR;
          end
        end
      end
      ST_BACKOFF: begin
        restart_n = restart_now;
        state_n   = ST_WAIT;
      end
      ST_DONE, ST_ERROR: begin
        if (hpd_rise) begin
          retry_n   = '0;
          restart_n = 1'b0;
          addr_n    = '0;
          state_n   = ST_FETCH;
        end
      end
      default: state_n = ST_STARTUP;
    endcase
  end

  always_comb begin
    romAddress  = addr_q;
    i2cWord     = word_q;
    i2cRequest  = (state == ST_WAIT);
    configDone  = (state == ST_DONE);
    configError = (state == ST_ERROR);
  end

endmodule

// File: tb/tb_hdmi_config_sequencer.sv
// Bench for hdmi_config_sequencer: ROM and I2C master models, a word scoreboard,
// a table of NACK scenarios and hand-written hot-plug / reset sequences.
module tb_hdmi_config_sequencer;
  localparam int BL = 24;
  localparam int AW = 4;
  localparam int SC = 8;
  localparam int MR = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          hotPlugDetect = 1'b0;
  logic          done_r = 1'b0;
  logic          nack_r = 1'b0;
  logic          stray_done = 1'b0;
  logic [AW-1:0] romAddress;
  logic [BL-1:0] romData;
  logic          i2cRequest;
  logic [BL-1:0] i2cWord;
  logic          configDone;
  logic          configError;

  hdmi_config_sequencer #(
    .bitLength(BL), .addressWidth(AW), .startupCycles(SC), .maxRetries(MR)
  ) dut (
    .clock(clock), .reset(reset), .hotPlugDetect(hotPlugDetect),
    .romAddress(romAddress), .romData(romData),
    .i2cRequest(i2cRequest), .i2cWord(i2cWord),
    .i2cDone(done_r | stray_done), .i2cAckError(nack_r | stray_done),
    .configDone(configDone), .configError(configError)
  );

  always #5 clock = ~clock;

  logic [BL-1:0] base_rom [16] = '{
    24'h724110, 24'h729803, 24'h729ae0, 24'h729c30,
    24'h729d61, 24'h72a2a4, 24'h72a3a4, 24'h72e0d0,
    24'h72f900, 24'h721500, 24'h721630, 24'h721702,
    24'h721802, 24'h72af06, 24'h72d003, 24'h725510
  };
  logic [BL-1:0] rom [16];

  always @(posedge clock) romData <= rom[romAddress];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  logic [BL-1:0] exp_q[$];
  int req_count = 0;
  int nack_entry = -1;
  int nack_count = 0;
  int nack_used = 0;
  int lat = 2;
  bit last_nack = 1'b0;
  int done_cyc = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // I2C master model: serves every request, NACKs the chosen entry a set number of times
  always begin : responder
    logic [BL-1:0] w;
    bit nack, held, aborted;
    @(posedge clock); #2;
    if (i2cRequest && !reset) begin
      req_count++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_request: got word %06h, none expected", i2cWord);
      end else begin
        w = exp_q.pop_front();
        check("request_word", i2cWord, w);
      end
      if (last_nack) check("backoff_gap", cyc - done_cyc, 1);
      nack = (int'(romAddress) == nack_entry) && (nack_used < nack_count);
      if (nack) nack_used++;
      held = 1'b1;
      aborted = 1'b0;
      for (int k = 0; k < lat; k++) begin
        @(posedge clock); #2;
        if (reset) begin
          aborted = 1'b1;
          break;
        end
        if (!i2cRequest) held = 1'b0;
      end
      if (!aborted) begin
        check("request_held", held, 1);
        done_r = 1'b1;
        nack_r = nack;
        @(posedge clock); #2;
        done_r = 1'b0;
        nack_r = 1'b0;
        done_cyc = cyc;
        last_nack = nack;
        check("request_fall", i2cRequest, 0);
      end
    end
  end

  task automatic load_rom(int n);
    for (int i = 0; i < 16; i++) rom[i] = (i < n) ? base_rom[i] : '0;
  endtask

  task automatic push_seq(int n, int ne, int nc);
    for (int i = 0; i < n; i++) begin
      int att;
      att = (i == ne) ? ((nc > MR) ? MR + 1 : nc + 1) : 1;
      for (int k = 0; k < att; k++) exp_q.push_back(base_rom[i]);
      if (i == ne && nc > MR) break;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    last_nack = 1'b0;
  endtask

  task automatic run_until_end(string name, int budget);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clock); #1;
      if (configDone || configError) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: no configDone/configError within %0d cycles", name, budget);
    end
  endtask

  task automatic count_to_request(string name, int expected);
    int n;
    bit hit;
    n = 0;
    hit = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clock); #1;
      n++;
      if (i2cRequest) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) n = -1;
    check(name, n, expected);
  endtask

  typedef struct {
    int n_entries;
    int nack_entry;
    int nack_count;
    int exp_reqs;
    int exp_done;
    int exp_err;
    int exp_addr;
  } vec_t;
  vec_t vecs[6];

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "global timeout");
  end

  initial begin : main
    int n;
    bit hit;
    vecs[0] = '{14, -1, 0, 14, 1, 0, 14};
    vecs[1] = '{14,  3, 1, 15, 1, 0, 14};
    vecs[2] = '{14,  0, 99, 4, 0, 1, 0};
    vecs[3] = '{16, -1, 0, 16, 1, 0, 15};
    vecs[4] = '{14,  7, 3, 17, 1, 0, 14};
    vecs[5] = '{14, 13, 4, 17, 0, 1, 13};

    // reset values and startup latency
    load_rom(14);
    push_seq(14, -1, 0);
    do_reset();
    check("reset_romAddress", romAddress, 0);
    check("reset_i2cRequest", i2cRequest, 0);
    check("reset_i2cWord", i2cWord, 0);
    check("reset_configDone", configDone, 0);
    check("reset_configError", configError, 0);
    count_to_request("startup_latency", 10);
    run_until_end("startup_run", 2000);
    check("startup_done", configDone, 1);
    check("startup_addr", romAddress, 14);
    check("startup_queue", exp_q.size(), 0);

    // done pulse with no request outstanding must be ignored
    stray_done = 1'b1;
    @(posedge clock); #1;
    stray_done = 1'b0;
    @(posedge clock); #1;
    check("stray_done_configDone", configDone, 1);
    check("stray_done_configError", configError, 0);
    check("stray_done_request", i2cRequest, 0);

    // hot-plug while DONE: replay without startup delay
    push_seq(14, -1, 0);
    hotPlugDetect = 1'b1;
    n = 0;
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      n++;
      if (!configDone) begin
        hit = 1'b1;
        break;
      end
    end
    check("hpd_done_fall", hit ? n : -1, 4);
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i2cRequest) begin
        hit = 1'b1;
        break;
      end
      @(posedge clock); #1;
      n++;
    end
    check("hpd_first_request", hit ? n : -1, 6);
    run_until_end("hpd_replay", 2000);
    check("hpd_replay_done", configDone, 1);
    check("hpd_replay_queue", exp_q.size(), 0);
    hotPlugDetect = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    check("hpd_fall_ignored", configDone, 1);

    // table of ROM / NACK scenarios
    for (int v = 0; v < 6; v++) begin
      load_rom(vecs[v].n_entries);
      exp_q.delete();
      push_seq(vecs[v].n_entries, vecs[v].nack_entry, vecs[v].nack_count);
      nack_entry = vecs[v].nack_entry;
      nack_count = vecs[v].nack_count;
      nack_used = 0;
      req_count = 0;
      do_reset();
      run_until_end($sformatf("vec%0d", v), 3000);
      check($sformatf("vec%0d_requests", v), req_count, vecs[v].exp_reqs);
      check($sformatf("vec%0d_configDone", v), configDone, vecs[v].exp_done);
      check($sformatf("vec%0d_configError", v), configError, vecs[v].exp_err);
      check($sformatf("vec%0d_romAddress", v), romAddress, vecs[v].exp_addr);
      check($sformatf("vec%0d_request_low", v), i2cRequest, 0);
      check($sformatf("vec%0d_queue", v), exp_q.size(), 0);
    end
    nack_entry = -1;
    nack_count = 0;

    // hot-plug while entry 5 is in flight: transfer completes, then replay from 0
    load_rom(14);
    exp_q.delete();
    push_seq(6, -1, 0);
    push_seq(14, -1, 0);
    lat = 8;
    do_reset();
    hit = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clock); #1;
      if (i2cRequest && i2cWord == 24'h72a2a4) begin
        hit = 1'b1;
        break;
      end
    end
    check("hpd_wait_entry5_seen", hit, 1);
    hotPlugDetect = 1'b1;
    run_until_end("hpd_wait", 3000);
    check("hpd_wait_done", configDone, 1);
    check("hpd_wait_queue", exp_q.size(), 0);
    hotPlugDetect = 1'b0;
    lat = 2;
    repeat (5) @(posedge clock);
    #1;

    // reset in the middle of a transfer
    load_rom(16);
    exp_q.delete();
    push_seq(16, -1, 0);
    do_reset();
    hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clock); #1;
      if (i2cRequest && romAddress == 4'd2) begin
        hit = 1'b1;
        break;
      end
    end
    check("midreset_entry2_seen", hit, 1);
    reset = 1'b1;
    @(posedge clock); #1;
    check("midreset_request", i2cRequest, 0);
    check("midreset_word", i2cWord, 0);
    check("midreset_addr", romAddress, 0);
    check("midreset_done", configDone, 0);
    check("midreset_error", configError, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    last_nack = 1'b0;
    exp_q.delete();
    push_seq(16, -1, 0);
    count_to_request("midreset_startup_latency", 10);
    run_until_end("midreset_run", 3000);
    check("midreset_run_done", configDone, 1);
    check("midreset_run_addr", romAddress, 15);
    check("midreset_run_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hdmi_config_sequencer.md
Name: hdmi_config_sequencer

Overview:
- Drives HDMI transmitter (ADV7513) register initialisation.
- Steps a registered config ROM (24-bit words: device address, register, data) one entry at a time and hands each word to the I2C write master over a request/done handshake.
- Retries NACKed writes, stops on an all-zero terminator word, and re-runs the whole sequence on a hot-plug rising edge, because the transmitter loses its register contents on hot-plug.

Parameters:
- bitLength, 24, config word width; must match the ROM and I2C master.
- addressWidth, 4, ROM address width; 2^addressWidth entries.
- startupCycles, 10000000, power-up hold-off in clocks (200 ms at 50 MHz); minimum 1.
- maxRetries, 3, extra attempts allowed per entry after a NACK.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- hotPlugDetect  in  1  asynchronous HPD from the transmitter; synchronised internally.
- romAddress  out  addressWidth  ROM entry address.
- romData  in  bitLength  ROM output, valid 1 clock after romAddress changes.
- i2cRequest  out  1  write request to the I2C master; held until i2cDone.
- i2cWord  out  bitLength  word to write; stable while i2cRequest is high.
- i2cDone  in  1  1-cycle pulse: transfer finished.
- i2cAckError  in  1  NACK flag; sampled only with i2cDone.
- configDone  out  1  sequence completed successfully (level).
- configError  out  1  retries exhausted (level).

Behaviour:
- Reset values: romAddress 0, i2cRequest 0, i2cWord 0, configDone 0, configError 0; state STARTUP; delay counter, retry counter, restart flag and HPD sync flops all 0.
- HPD handling: 2-flop synchroniser plus edge register. A rise is detected 3 clocks after the input rises.
- STARTUP: counts startupCycles clocks, then goes to FETCH with romAddress 0. HPD rises are ignored here.
- FETCH: 1 wait cycle for ROM latency, then goes to CHECK.
- CHECK:
  - romData == 0: go to DONE; no request is issued.
  - Otherwise: latch i2cWord <= romData, set i2cRequest = 1, go to WAIT.
- WAIT:
  - i2cRequest stays 1 until i2cDone is seen, then falls on the next clock.
  - Done without NACK: clear the retry counter.
    - Restart flag set: go to FETCH at address 0 and clear the flag.
    - Else romAddress == 2^addressWidth-1: go to DONE. No wrap-around.
    - Else romAddress + 1, go to FETCH.
  - Done with NACK and retries < maxRetries: increment retries, go to BACKOFF.
  - Done with NACK and retries == maxRetries: go to ERROR.
- BACKOFF: i2cRequest is 0 for exactly 1 clock, then the same i2cWord is reasserted (WAIT). The ROM is not re-read.
- DONE: configDone = 1.
- ERROR: configError = 1, i2cRequest = 0.
- Leaving DONE or ERROR: only an HPD rise or reset. On an HPD rise, configDone and configError clear on the next clock, the retry counter clears, and the sequencer goes to FETCH at address 0. There is no startup delay on this path.
- HPD rise while in FETCH/CHECK/WAIT/BACKOFF:
  - Sets the restart flag; the in-flight I2C transfer is never aborted.
  - The flag is acted on at the next successful i2cDone, or at a CHECK that finds a terminator.
  - A NACK retry in progress completes its retry first.
  - Exhausted retries with the flag set go to FETCH at address 0, not to ERROR.
- i2cDone while i2cRequest is 0: ignored.
- i2cDone and an HPD rise in the same cycle: the HPD rise sets the restart flag; the done is processed the same cycle with the flag considered set.
- configDone and configError are never 1 at the same time.
- Reset in any state: all outputs return to reset values on the next clock and startup restarts, even mid-transfer. The I2C master is reset from the same reset.

Test Plan:
1. startupCycles=8; ROM entries 0-13 nonzero (0x724110 … 0x72af06), entry 14 = 0 -> first i2cRequest with i2cWord=0x724110 about 10 clocks after reset; exactly 14 requests in ROM order; configDone=1 after entry 14 is fetched; no request carries 0x000000.
2. NACK on entry 3 once -> 0x729c30 is requested twice with exactly one low cycle between; sequence completes; configError=0.
3. maxRetries=3, NACK every attempt on entry 0 -> 4 requests of 0x724110, then configError=1, configDone=0, i2cRequest=0, romAddress stays 0.
4. In DONE, pulse hotPlugDetect high -> configDone falls 4 clocks after the HPD edge; the sequence re-runs starting with 0x724110 without the startup delay.
5. HPD rise while entry 5 (0x72a2a4) is in WAIT -> i2cRequest is held until i2cDone; the next request is 0x724110, not 0x72a3a4.
6. All 16 ROM entries nonzero -> 16 requests; configDone after entry 15; romAddress holds 15 and never wraps to 0. Also, reset asserted mid-WAIT -> outputs are 0 on the next clock and the startup count restarts.
